chunked_add_sub: RTL and testbench
==================================

CHUNKED_ADD_SUB -- requirements
Module: chunked_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, with CHUNK >= 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 SHALL have port x, input, WIDTH, first operand.
REQ-008 SHALL have port y, input, WIDTH, second operand.
REQ-009 SHALL have port func, input, 3, operation code: 010 add, 011 sub, 000 inc (x+1), 001 dec (x-1), 1xx same as 0xx with signed saturation.
REQ-010 SHALL have port out_valid, output, 1, result present.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port c, output, WIDTH, result.
REQ-013 SHALL have port flags, output, 3, {carry, overflow, zero}.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-015 SHALL assert in_ready only in IDLE, and SHALL accept a request on a clk edge with in_valid and in_ready both high.
REQ-016 On accept, SHALL capture x, the effective operand (y if func[1]=1, else 1), and func, and SHALL enter BUSY with chunk index 0 and carry-in equal to func[0].
REQ-017 In BUSY, each cycle SHALL add chunk k of x, chunk k of the effective operand (inverted when func[0]=1), and the stored carry, SHALL store the CHUNK-bit sum into result chunk k, and SHALL register the carry-out.
REQ-018 After chunk WIDTH/CHUNK-1, SHALL enter DONE; out_valid SHALL rise exactly WIDTH/CHUNK cycles after the accepting edge.
REQ-019 Carry flag SHALL be the final carry-out; for sub and dec, carry=1 means no borrow.
REQ-020 Overflow flag SHALL be set on two's-complement signed overflow of the full WIDTH result.
REQ-021 Zero flag SHALL be set when the presented c equals 0.
REQ-022 With func[2]=1 and overflow, c SHALL be 2^(WIDTH-1)-1 when the true result is positive and 2^(WIDTH-1) when negative; the overflow flag stays set.
REQ-023 In DONE, c and flags SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 SHALL return to IDLE on a clk edge in DONE with out_ready=1.
REQ-025 A new request SHALL NOT be accepted in the same edge as result hand-off; throughput is one op per WIDTH/CHUNK+2 cycles.
REQ-026 Changes on x, y and func while BUSY or DONE SHALL have no effect.
REQ-027 When CHUNK=WIDTH, latency SHALL be 1 cycle in BUSY.

Reset
REQ-028 rst_n low SHALL force state IDLE, in_ready=1, out_valid=0, c=0, flags=0, carry register=0 and chunk index=0, asynchronously.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL abort the operation; no out_valid SHALL appear for it after release.
REQ-030 The first accept SHALL be possible on the first clk edge with rst_n high.

Configuration
REQ-031 Macro CHUNKED_ADD_SUB_FLAGS_EN defined SHALL compile in flag computation and the saturation mode as specified.
REQ-032 Without CHUNKED_ADD_SUB_FLAGS_EN, flags SHALL be tied to 0 and func[2] SHALL be ignored, with no saturation; all other behaviour is unchanged.

Verification (WIDTH=32, CHUNK=8, macro defined unless stated)
REQ-033 Add: x=0x0000_00FF, y=0x0000_0001, func=010 -> c=0x0000_0100 and flags=000, with out_valid 4 cycles after accept.
REQ-034 Sub: x=5, y=5, func=011 -> c=0 and flags=101; dec: x=0, func=001 -> c=0xFFFF_FFFF and flags=000.
REQ-035 Saturating add: x=0x7FFF_FFFF, y=1, func=110 -> c=0x7FFF_FFFF and flags=010; the same inputs with func=010 -> c=0x8000_0000 and flags=010.
REQ-036 Backpressure: out_ready held 0 for 10 cycles after out_valid -> c, flags and out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-037 Reset: rst_n pulsed low 2 cycles into BUSY -> out_valid=0, c=0 and in_ready=1 immediately, and no stale result afterwards.
REQ-038 Macro undefined: x=0x7FFF_FFFF, y=1, func=110 -> c=0x8000_0000 and flags=000.

Source files
------------

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: processes CHUNK bits per cycle with a registered carry.
// Define CHUNKED_ADD_SUB_FLAGS_EN to build the {carry, overflow, zero} flags and signed saturation.
module chunked_add_sub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [2:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [2:0]       flags
);

    localparam int NUM   = WIDTH / CHUNK;
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   x_reg;
    logic [WIDTH-1:0]   op_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic [WIDTH-1:0]   c_reg;
    logic [1:0]         func_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;
    logic [2:0]         flags_reg;

    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH-1:0]   sum_full;
    logic [WIDTH-1:0]   result_final;
    logic [CHUNK:0]     chunk_res;
    logic [2:0]         flags_final;
    logic               last_chunk;
    int                 base;

    // sum_full is the partial result with the current chunk already merged in
    always_comb begin
        base       = int'(idx) * CHUNK;
        b_eff      = func_reg[0] ? ~op_reg : op_reg;
        chunk_res  = {1'b0, x_reg[base +: CHUNK]} + {1'b0, b_eff[base +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry_reg};
        sum_full   = sum_reg;
        sum_full[base +: CHUNK] = chunk_res[CHUNK-1:0];
        last_chunk = (idx == IDX_W'(NUM - 1));
    end

`ifdef CHUNKED_ADD_SUB_FLAGS_EN
    logic sat_reg;
    logic ovf;

    // On overflow the true result has the sign of x, since both operands share it
    always_comb begin
        ovf          = (x_reg[WIDTH-1] == b_eff[WIDTH-1]) && (sum_full[WIDTH-1] != x_reg[WIDTH-1]);
        result_final = sum_full;
        if (sat_reg && ovf) begin
            result_final = x_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        flags_final  = {chunk_res[CHUNK], ovf, (result_final == '0)};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_reg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sat_reg <= func[2];
        end
    end
`else
    logic unused_func2;
    assign unused_func2 = func[2];

    always_comb begin
        result_final = sum_full;
        flags_final  = '0;
    end
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = BUSY;
            BUSY:    if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are frozen at accept so input changes during BUSY/DONE are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_reg     <= '0;
            op_reg    <= '0;
            sum_reg   <= '0;
            c_reg     <= '0;
            func_reg  <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            flags_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_reg     <= x;
                        op_reg    <= func[1] ? y : WIDTH'(1);
                        func_reg  <= func[1:0];
                        carry_reg <= func[0];
                        idx       <= '0;
                        sum_reg   <= '0;
                    end
                end
                BUSY: begin
                    sum_reg   <= sum_full;
                    carry_reg <= chunk_res[CHUNK];
                    if (last_chunk) begin
                        idx       <= '0;
                        c_reg     <= result_final;
                        flags_reg <= flags_final;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign c         = c_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_chunked_add_sub.sv
// Scoreboard bench for chunked_add_sub: random and directed operations against an arithmetic model.
`timescale 1ns/1ps
module tb_chunked_add_sub;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int NUM   = WIDTH / CHUNK;

    typedef struct {
        logic [31:0] c;
        logic [2:0]  fl;
        longint      t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] y = '0;
    logic [2:0]  func = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] c;
    logic [2:0]  flags;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic prev_valid = 1'b0;
    logic rand_bp = 1'b0;
    logic hold_ready = 1'b1;

    chunked_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .func(func), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: signed/unsigned arithmetic on wide integers, no chunking
    function automatic void model(input logic [31:0] a, input logic [31:0] b_in, input logic [2:0] f,
                                  output logic [31:0] ce, output logic [2:0] fle);
        logic [31:0] b;
        longint      sa, sb, tr;
        logic [32:0] usum;
        logic        carry, ovf;
        b     = f[1] ? b_in : 32'd1;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        tr    = f[0] ? (sa - sb) : (sa + sb);
        usum  = {1'b0, a} + {1'b0, b};
        carry = f[0] ? (a >= b) : usum[32];
        ovf   = (tr > 64'sd2147483647) || (tr < -64'sd2147483648);
        ce    = tr[31:0];
`ifdef CHUNKED_ADD_SUB_FLAGS_EN
        if (f[2] && ovf) ce = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        fle = {carry, ovf, (ce == 32'd0)};
`else
        fle = 3'b000;
        if (carry || ovf) fle = 3'b000;
`endif
    endfunction

    task automatic applyStimulus(input logic [31:0] ax, input logic [31:0] ay, input logic [2:0] af);
        exp_t        e;
        logic [31:0] ce;
        logic [2:0]  fle;
        int          guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        x = ax;
        y = ay;
        func = af;
        in_valid = 1'b1;
        model(ax, ay, af, ce, fle);
        @(posedge clk);
        e.c  = ce;
        e.fl = fle;
        e.t  = longint'($time);
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
        x = $urandom;
        y = $urandom;
        func = 3'($urandom_range(0, 7));
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : hold_ready;
    end

    // Monitor: checks latency on the rising edge of out_valid and the result at hand-off
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("latency", 64'($time) - 64'(exp_q[0].t), 64'(NUM * 10 + 5));
                    checkOutput("in_ready_while_valid", 64'(in_ready), 64'd0);
                end
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                checkOutput("c", 64'(c), 64'(mon_e.c));
                checkOutput("flags", 64'(flags), 64'(mon_e.fl));
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] held_c;
        logic [2:0]  held_f;
        logic [31:0] rx;
        int          guard;
        int          stale;

        #2;
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_c", 64'(c), 64'd0);
        checkOutput("reset_flags", 64'(flags), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 3'b010);
        applyStimulus(32'd5, 32'd5, 3'b011);
        applyStimulus(32'd0, 32'h1234_5678, 3'b001);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b110);
        applyStimulus(32'h7FFF_FFFF, 32'd1, 3'b010);
        applyStimulus(32'h8000_0000, 32'd1, 3'b111);
        applyStimulus(32'hFFFF_FFFF, 32'd0, 3'b000);
        applyStimulus(32'h8000_0000, 32'h8000_0000, 3'b110);

        $display("[TB] backpressure");
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        hold_ready = 1'b0;
        @(posedge clk);
        applyStimulus(32'h0F0F_F0F0, 32'h1111_2222, 3'b011);
        guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bp_out_valid_seen", 64'(out_valid), 64'd1);
        held_c = c;
        held_f = flags;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (c !== held_c || flags !== held_f || out_valid !== 1'b1 || in_ready !== 1'b0) stale++;
        end
        checkOutput("bp_hold_stable_errors", 64'(stale), 64'd0);
        hold_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("bp_release_in_ready", 64'(in_ready), 64'd1);
        checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(32'h1234_5678, 32'h0101_0101, 3'b010);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort_c", 64'(c), 64'd0);
        checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
        checkOutput("abort_flags", 64'(flags), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        checkOutput("abort_stale_out_valid", 64'(stale), 64'd0);

        $display("[TB] random operations");
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0:       rx = 32'h7FFF_FFFF;
                1:       rx = 32'h8000_0000;
                2:       rx = 32'd0;
                3:       rx = 32'hFFFF_FFFF;
                default: rx = $urandom;
            endcase
            applyStimulus(rx, ($urandom_range(0, 3) == 0) ? rx : $urandom, 3'($urandom_range(0, 7)));
        end
        rand_bp = 1'b0;
        hold_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("drain_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
